// File: rtl/control_unit_pipelined.sv
// Pipelined control unit for the RV32I core. It contains the decode stage, the
// ID/EX control register, execute-stage branch resolution and the data-memory
// wait FSM.
// Optional feature: define MEM_TIMEOUT_EN to enable the memory-timeout fault
// (WAIT -> FAULT after MEM_WAIT_MAX stall cycles).

module control_unit_pipelined #(
   parameter int unsigned ALU_CTRL_W   = 4,
   parameter int unsigned IMM_SRC_W    = 3,
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [6:0]            op_i,
   input  logic [2:0]            funct3_i,
   input  logic                  funct7_5_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic                  zero_i,
   input  logic                  lt_i,
   input  logic                  ltu_i,
   input  logic                  mem_ready_i,
   output logic [IMM_SRC_W-1:0]  imm_src_d_o,
   output logic                  reg_write_e_o,
   output logic [1:0]            result_src_e_o,
   output logic                  mem_write_e_o,
   output logic                  alu_src_e_o,
   output logic [ALU_CTRL_W-1:0] alu_control_e_o,
   output logic                  jalr_e_o,
   output logic                  byte_address_e_o,
   output logic                  pc_src_e_o,
   output logic                  mem_stall_o,
   output logic                  illegal_instr_o,
   output logic                  mem_fault_o
);

   // Opcodes
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I_ALU  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   // Immediate types
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_J = 3'b011;
   localparam logic [2:0] IMM_U = 3'b100;

   // Result select
   localparam logic [1:0] RES_ALU = 2'b00;
   localparam logic [1:0] RES_MEM = 2'b01;
   localparam logic [1:0] RES_PC4 = 2'b10;

   // ALU operations
   localparam logic [3:0] ALU_ADD   = 4'd0;
   localparam logic [3:0] ALU_SUB   = 4'd1;
   localparam logic [3:0] ALU_AND   = 4'd2;
   localparam logic [3:0] ALU_OR    = 4'd3;
   localparam logic [3:0] ALU_XOR   = 4'd4;
   localparam logic [3:0] ALU_SLT   = 4'd5;
   localparam logic [3:0] ALU_SLTU  = 4'd6;
   localparam logic [3:0] ALU_SLL   = 4'd7;
   localparam logic [3:0] ALU_SRL   = 4'd8;
   localparam logic [3:0] ALU_SRA   = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   // Elaboration-time guard on the configuration
   if (ALU_CTRL_W < 4 || IMM_SRC_W < 3 || MEM_WAIT_MAX < 1) begin : g_param_check
      $error("control_unit_pipelined: parameter out of range");
   end

   // ID/EX control payload; an all-zero value is a bubble
   typedef struct packed {
      logic                  reg_write;
      logic [1:0]            result_src;
      logic                  mem_write;
      logic                  alu_src;
      logic [ALU_CTRL_W-1:0] alu_control;
      logic                  jalr;
      logic                  byte_address;
      logic                  branch;
      logic                  jump;
      logic                  mem_op;
      logic                  illegal;
      logic [2:0]            funct3;
   } idex_t;

   localparam idex_t BUBBLE = '0;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_FAULT = 2'd2
   } mem_state_e;

   idex_t      dec_c;
   idex_t      idex_d, idex_q;
   logic [2:0] imm_src_c;
   logic [3:0] alu_op_c;
   logic       byte_c;
   logic       cond_c;
   logic       mem_stall_c;
   logic       fault_bubble_c;
   mem_state_e state_d, state_q;

`ifdef MEM_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MEM_WAIT_MAX + 1);
   logic [CNT_W-1:0] cnt_d, cnt_q;
`endif

   // ALU operation for R-type and I-ALU; funct7[5] qualifies ADD/SUB only for R-type
   always_comb begin
      alu_op_c = ALU_ADD;
      case (funct3_i)
         3'b000:  alu_op_c = (op_i == OP_R && funct7_5_i) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_op_c = ALU_SLL;
         3'b010:  alu_op_c = ALU_SLT;
         3'b011:  alu_op_c = ALU_SLTU;
         3'b100:  alu_op_c = ALU_XOR;
         3'b101:  alu_op_c = funct7_5_i ? ALU_SRA : ALU_SRL;
         3'b110:  alu_op_c = ALU_OR;
         3'b111:  alu_op_c = ALU_AND;
         default: alu_op_c = ALU_ADD;
      endcase
   end

   assign byte_c = (funct3_i == 3'b000) || (funct3_i == 3'b100);

   // Decode-stage control generation
   always_comb begin
      dec_c     = BUBBLE;
      imm_src_c = IMM_I;
      case (op_i)
         OP_LOAD: begin
            dec_c.reg_write    = 1'b1;
            dec_c.result_src   = RES_MEM;
            dec_c.alu_src      = 1'b1;
            dec_c.alu_control  = ALU_CTRL_W'(ALU_ADD);
            dec_c.mem_op       = 1'b1;
            dec_c.byte_address = byte_c;
            imm_src_c          = IMM_I;
         end
         OP_STORE: begin
            dec_c.mem_write    = 1'b1;
            dec_c.alu_src      = 1'b1;
            dec_c.alu_control  = ALU_CTRL_W'(ALU_ADD);
            dec_c.mem_op       = 1'b1;
            dec_c.byte_address = byte_c;
            imm_src_c          = IMM_S;
         end
         OP_R: begin
            dec_c.reg_write   = 1'b1;
            dec_c.result_src  = RES_ALU;
            dec_c.alu_control = ALU_CTRL_W'(alu_op_c);
         end
         OP_I_ALU: begin
            dec_c.reg_write   = 1'b1;
            dec_c.result_src  = RES_ALU;
            dec_c.alu_src     = 1'b1;
            dec_c.alu_control = ALU_CTRL_W'(alu_op_c);
            imm_src_c         = IMM_I;
         end
         OP_BRANCH: begin
            dec_c.branch      = 1'b1;
            dec_c.alu_control = ALU_CTRL_W'(ALU_SUB);
            imm_src_c         = IMM_B;
         end
         OP_JAL: begin
            dec_c.reg_write  = 1'b1;
            dec_c.result_src = RES_PC4;
            dec_c.jump       = 1'b1;
            imm_src_c        = IMM_J;
         end
         OP_JALR: begin
            dec_c.reg_write   = 1'b1;
            dec_c.result_src  = RES_PC4;
            dec_c.alu_src     = 1'b1;
            dec_c.alu_control = ALU_CTRL_W'(ALU_ADD);
            dec_c.jump        = 1'b1;
            dec_c.jalr        = 1'b1;
            imm_src_c         = IMM_I;
         end
         OP_LUI: begin
            dec_c.reg_write   = 1'b1;
            dec_c.alu_src     = 1'b1;
            dec_c.alu_control = ALU_CTRL_W'(ALU_PASSB);
            imm_src_c         = IMM_U;
         end
         OP_AUIPC: begin
            dec_c.reg_write   = 1'b1;
            dec_c.alu_src     = 1'b1;
            dec_c.alu_control = ALU_CTRL_W'(ALU_ADD);
            imm_src_c         = IMM_U;
         end
         default: begin
            dec_c.illegal = 1'b1;
            imm_src_c     = IMM_I;
         end
      endcase
      dec_c.funct3 = funct3_i;
   end

   assign imm_src_d_o = IMM_SRC_W'(imm_src_c);

   // ID/EX next value: memory wait holds, fault/flush bubble, hazard stall holds
   always_comb begin
      idex_d = dec_c;
      if (mem_stall_c) begin
         idex_d = idex_q;
      end else if (fault_bubble_c || flush_i) begin
         idex_d = BUBBLE;
      end else if (stall_i) begin
         idex_d = idex_q;
      end
   end

   // ID/EX control register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex_q <= BUBBLE;
      end else begin
         idex_q <= idex_d;
      end
   end

   // Branch condition from EX funct3 and ALU flags; 010/011 never taken
   always_comb begin
      cond_c = 1'b0;
      case (idex_q.funct3)
         3'b000:  cond_c = zero_i;
         3'b001:  cond_c = !zero_i;
         3'b100:  cond_c = lt_i;
         3'b101:  cond_c = !lt_i;
         3'b110:  cond_c = ltu_i;
         3'b111:  cond_c = !ltu_i;
         default: cond_c = 1'b0;
      endcase
   end

   // Memory FSM state register (plus wait counter when timeouts are enabled)
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
`ifdef MEM_TIMEOUT_EN
         cnt_q   <= cnt_d;
`endif
      end
   end

   // Memory FSM next-state logic
   always_comb begin
      state_d = state_q;
`ifdef MEM_TIMEOUT_EN
      cnt_d   = cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (idex_q.mem_op && !mem_ready_i) begin
               state_d = S_WAIT;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = CNT_W'(1);
`endif
            end
         end
         S_WAIT: begin
            if (mem_ready_i) begin
               state_d = S_IDLE;
`ifdef MEM_TIMEOUT_EN
               cnt_d   = '0;
            end else if (cnt_q == CNT_W'(MEM_WAIT_MAX)) begin
               state_d = S_FAULT;
            end else begin
               cnt_d   = cnt_q + CNT_W'(1);
`endif
            end
         end
         S_FAULT: begin
`ifdef MEM_TIMEOUT_EN
            state_d = S_FAULT;
`else
            state_d = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Memory FSM outputs; a same-cycle ready costs no stall
   always_comb begin
      mem_stall_c    = 1'b0;
      fault_bubble_c = 1'b0;
      case (state_q)
         S_IDLE:  mem_stall_c    = idex_q.mem_op && !mem_ready_i;
         S_WAIT:  mem_stall_c    = 1'b1;
         S_FAULT: fault_bubble_c = 1'b1;
         default: mem_stall_c    = 1'b0;
      endcase
   end

   assign mem_stall_o      = mem_stall_c;
`ifdef MEM_TIMEOUT_EN
   assign mem_fault_o      = (state_q == S_FAULT);
`else
   assign mem_fault_o      = 1'b0;
`endif

   assign reg_write_e_o    = idex_q.reg_write;
   assign result_src_e_o   = idex_q.result_src;
   assign mem_write_e_o    = idex_q.mem_write;
   assign alu_src_e_o      = idex_q.alu_src;
   assign alu_control_e_o  = idex_q.alu_control;
   assign jalr_e_o         = idex_q.jalr;
   assign byte_address_e_o = idex_q.byte_address;
   assign pc_src_e_o       = (idex_q.jump || (idex_q.branch && cond_c)) && !mem_stall_c;
   assign illegal_instr_o  = idex_q.illegal ||
                             (idex_q.branch && (idex_q.funct3[2:1] == 2'b01));

endmodule

// File: tb/tb_control_unit_pipelined.sv
// Directed self-checking bench for control_unit_pipelined.
module tb_control_unit_pipelined;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [6:0] op_i;
   logic [2:0] funct3_i;
   logic       funct7_5_i;
   logic       stall_i;
   logic       flush_i;
   logic       zero_i;
   logic       lt_i;
   logic       ltu_i;
   logic       mem_ready_i;
   logic [2:0] imm_src_d_o;
   logic       reg_write_e_o;
   logic [1:0] result_src_e_o;
   logic       mem_write_e_o;
   logic       alu_src_e_o;
   logic [3:0] alu_control_e_o;
   logic       jalr_e_o;
   logic       byte_address_e_o;
   logic       pc_src_e_o;
   logic       mem_stall_o;
   logic       illegal_instr_o;
   logic       mem_fault_o;

   int total = 0;
   int bad   = 0;

   control_unit_pipelined #(
      .ALU_CTRL_W   (4),
      .IMM_SRC_W    (3),
      .MEM_WAIT_MAX (4)
   ) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .op_i             (op_i),
      .funct3_i         (funct3_i),
      .funct7_5_i       (funct7_5_i),
      .stall_i          (stall_i),
      .flush_i          (flush_i),
      .zero_i           (zero_i),
      .lt_i             (lt_i),
      .ltu_i            (ltu_i),
      .mem_ready_i      (mem_ready_i),
      .imm_src_d_o      (imm_src_d_o),
      .reg_write_e_o    (reg_write_e_o),
      .result_src_e_o   (result_src_e_o),
      .mem_write_e_o    (mem_write_e_o),
      .alu_src_e_o      (alu_src_e_o),
      .alu_control_e_o  (alu_control_e_o),
      .jalr_e_o         (jalr_e_o),
      .byte_address_e_o (byte_address_e_o),
      .pc_src_e_o       (pc_src_e_o),
      .mem_stall_o      (mem_stall_o),
      .illegal_instr_o  (illegal_instr_o),
      .mem_fault_o      (mem_fault_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      op_i       = op;
      funct3_i   = f3;
      funct7_5_i = f7;
   endtask

   initial begin
      rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      zero_i = 1'b0; lt_i = 1'b0; ltu_i = 1'b0; mem_ready_i = 1'b1;
      instr(7'b0110011, 3'b000, 1'b1);
      tick();
      chk("rst_reg_write", 32'(reg_write_e_o), 32'd0);
      chk("rst_alu_ctrl", 32'(alu_control_e_o), 32'd0);
      chk("rst_mem_write", 32'(mem_write_e_o), 32'd0);
      chk("rst_pc_src", 32'(pc_src_e_o), 32'd0);
      chk("rst_mem_stall", 32'(mem_stall_o), 32'd0);
      chk("rst_illegal", 32'(illegal_instr_o), 32'd0);
      chk("rst_fault", 32'(mem_fault_o), 32'd0);
      rst_i = 1'b0;

      // R-type SUB
      tick();
      chk("sub_alu", 32'(alu_control_e_o), 32'd1);
      chk("sub_rw", 32'(reg_write_e_o), 32'd1);
      chk("sub_res", 32'(result_src_e_o), 32'd0);
      chk("sub_alusrc", 32'(alu_src_e_o), 32'd0);

      // ADDI with funct7[5]=1 stays ADD
      instr(7'b0010011, 3'b000, 1'b1);
      #1 chk("addi_imm", 32'(imm_src_d_o), 32'd0);
      tick();
      chk("addi_alu", 32'(alu_control_e_o), 32'd0);
      chk("addi_alusrc", 32'(alu_src_e_o), 32'd1);

      // SRAI
      instr(7'b0010011, 3'b101, 1'b1);
      tick();
      chk("srai_alu", 32'(alu_control_e_o), 32'd9);

      // LUI
      instr(7'b0110111, 3'b000, 1'b0);
      #1 chk("lui_imm", 32'(imm_src_d_o), 32'd4);
      tick();
      chk("lui_alu", 32'(alu_control_e_o), 32'd10);
      chk("lui_alusrc", 32'(alu_src_e_o), 32'd1);

      // SB store
      instr(7'b0100011, 3'b000, 1'b0);
      #1 chk("sb_imm", 32'(imm_src_d_o), 32'd1);
      tick();
      chk("sb_mw", 32'(mem_write_e_o), 32'd1);
      chk("sb_byte", 32'(byte_address_e_o), 32'd1);
      chk("sb_rw", 32'(reg_write_e_o), 32'd0);
      chk("sb_nostall", 32'(mem_stall_o), 32'd0);

      // BLT
      instr(7'b1100011, 3'b100, 1'b0);
      #1 chk("blt_imm", 32'(imm_src_d_o), 32'd2);
      tick();
      chk("blt_alu", 32'(alu_control_e_o), 32'd1);
      lt_i = 1'b1;
      #1 chk("blt_taken", 32'(pc_src_e_o), 32'd1);
      lt_i = 1'b0;
      #1 chk("blt_not", 32'(pc_src_e_o), 32'd0);

      // BGEU
      instr(7'b1100011, 3'b111, 1'b0);
      tick();
      ltu_i = 1'b0;
      #1 chk("bgeu_taken", 32'(pc_src_e_o), 32'd1);
      ltu_i = 1'b1;
      #1 chk("bgeu_not", 32'(pc_src_e_o), 32'd0);

      // BEQ
      instr(7'b1100011, 3'b000, 1'b0);
      tick();
      zero_i = 1'b1;
      #1 chk("beq_taken", 32'(pc_src_e_o), 32'd1);

      // Branch funct3=010 is illegal and never taken
      instr(7'b1100011, 3'b010, 1'b0);
      tick();
      zero_i = 1'b1; lt_i = 1'b1; ltu_i = 1'b1;
      #1 chk("br010_pc", 32'(pc_src_e_o), 32'd0);
      chk("br010_ill", 32'(illegal_instr_o), 32'd1);
      zero_i = 1'b0; lt_i = 1'b0; ltu_i = 1'b0;

      // JAL
      instr(7'b1101111, 3'b000, 1'b0);
      #1 chk("jal_imm", 32'(imm_src_d_o), 32'd3);
      tick();
      chk("jal_pc", 32'(pc_src_e_o), 32'd1);
      chk("jal_res", 32'(result_src_e_o), 32'd2);
      chk("jal_jalr", 32'(jalr_e_o), 32'd0);

      // JALR
      instr(7'b1100111, 3'b000, 1'b0);
      tick();
      chk("jalr_jalr", 32'(jalr_e_o), 32'd1);
      chk("jalr_pc", 32'(pc_src_e_o), 32'd1);
      chk("jalr_alusrc", 32'(alu_src_e_o), 32'd1);

      // Flush beats stall
      instr(7'b0110011, 3'b000, 1'b0);
      stall_i = 1'b1; flush_i = 1'b1;
      tick();
      chk("flush_rw", 32'(reg_write_e_o), 32'd0);
      chk("flush_pc", 32'(pc_src_e_o), 32'd0);
      chk("flush_jalr", 32'(jalr_e_o), 32'd0);
      stall_i = 1'b0; flush_i = 1'b0;

      // Stall holds ID/EX
      tick();
      chk("add_rw", 32'(reg_write_e_o), 32'd1);
      instr(7'b0110111, 3'b000, 1'b0);
      stall_i = 1'b1;
      tick();
      chk("stall_alusrc", 32'(alu_src_e_o), 32'd0);
      chk("stall_alu", 32'(alu_control_e_o), 32'd0);
      stall_i = 1'b0;

      // Illegal opcode
      instr(7'b1111111, 3'b000, 1'b0);
      #1 chk("ill_imm", 32'(imm_src_d_o), 32'd0);
      tick();
      chk("ill_flag", 32'(illegal_instr_o), 32'd1);
      chk("ill_rw", 32'(reg_write_e_o), 32'd0);
      chk("ill_mw", 32'(mem_write_e_o), 32'd0);
      chk("ill_pc", 32'(pc_src_e_o), 32'd0);

      // Load with three stall cycles; flush mid-wait ignored
      instr(7'b0000011, 3'b010, 1'b0);
      tick();
      chk("lw_ill_clear", 32'(illegal_instr_o), 32'd0);
      mem_ready_i = 1'b0;
      instr(7'b0110011, 3'b000, 1'b1);
      #1 chk("lw_stall1", 32'(mem_stall_o), 32'd1);
      chk("lw_res", 32'(result_src_e_o), 32'd1);
      chk("lw_byte", 32'(byte_address_e_o), 32'd0);
      chk("lw_rw", 32'(reg_write_e_o), 32'd1);
      tick();
      flush_i = 1'b1;
      #1 chk("lw_stall2", 32'(mem_stall_o), 32'd1);
      chk("lw_res2", 32'(result_src_e_o), 32'd1);
      tick();
      flush_i = 1'b0; mem_ready_i = 1'b1;
      #1 chk("lw_stall3", 32'(mem_stall_o), 32'd1);
      chk("lw_res3", 32'(result_src_e_o), 32'd1);
      chk("lw_rw3", 32'(reg_write_e_o), 32'd1);
      tick();
      chk("lw_done", 32'(mem_stall_o), 32'd0);
      chk("lw_held", 32'(result_src_e_o), 32'd1);
      tick();
      chk("after_lw_alu", 32'(alu_control_e_o), 32'd1);
      chk("after_lw_res", 32'(result_src_e_o), 32'd0);

      // Reset in the middle of a wait
      instr(7'b0000011, 3'b000, 1'b0);
      tick();
      mem_ready_i = 1'b0;
      instr(7'b0110011, 3'b000, 1'b0);
      #1 chk("rw_stall", 32'(mem_stall_o), 32'd1);
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      #1 chk("rw_nostall", 32'(mem_stall_o), 32'd0);
      chk("rw_bubble", 32'(reg_write_e_o), 32'd0);
      chk("rw_res", 32'(result_src_e_o), 32'd0);
      mem_ready_i = 1'b1;
      tick();

`ifdef MEM_TIMEOUT_EN
      // Store timing out after MEM_WAIT_MAX wait cycles
      instr(7'b0100011, 3'b010, 1'b0);
      tick();
      mem_ready_i = 1'b0;
      instr(7'b0110011, 3'b000, 1'b0);
      #1 chk("to_stall", 32'(mem_stall_o), 32'd1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("to_nofault", 32'(mem_fault_o), 32'd0);
         chk("to_waiting", 32'(mem_stall_o), 32'd1);
      end
      tick();
      chk("to_fault", 32'(mem_fault_o), 32'd1);
      chk("to_stall_off", 32'(mem_stall_o), 32'd0);
      tick();
      chk("to_bubble", 32'(mem_write_e_o), 32'd0);
      mem_ready_i = 1'b1;
      tick();
      tick();
      chk("to_sticky", 32'(mem_fault_o), 32'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("to_cleared", 32'(mem_fault_o), 32'd0);
`else
      chk("no_fault", 32'(mem_fault_o), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
